// File: rtl/fetch_hold_ctrl_pkg.sv
// rtl/fetch_hold_ctrl_pkg.sv - shared constants, state type and helpers for the fetch/hold controller
package fetch_hold_ctrl_pkg;

    localparam int INSN_W   = 32;
    localparam int OPCODE_W = 6;

    localparam logic [31:0]         PC_RESET_DEF = 32'h0000_3000;
    localparam logic [INSN_W-1:0]   NOP          = 32'h0000_0000;
    localparam logic [OPCODE_W-1:0] OP_BEQ       = 6'b000100;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } fetch_state_e;

    // Redirect targets are word addresses; the low two bits carry no meaning.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_hold_ctrl_hold_ctr.sv
// rtl/fetch_hold_ctrl_hold_ctr.sv - saturating stall counter, stop run-length watchdog and sticky hang flag
module fetch_hold_ctrl_hold_ctr #(
    parameter int WD_LIMIT = 16,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stop_i,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic             hang_o
);

    localparam int              RUN_W   = $clog2(WD_LIMIT + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(WD_LIMIT);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             hang_q, hang_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            run_q  <= '0;
            hang_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            hang_q <= hang_d;
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        run_d  = run_q;
        hang_d = hang_q;
        if (stop_i) begin
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (run_q != RUN_MAX) begin
                run_d = run_q + RUN_W'(1);
            end
            // Hang latches on the very edge the run length reaches the limit.
            if (run_d == RUN_MAX) begin
                hang_d = 1'b1;
            end
        end else begin
            run_d = '0;
        end
    end

    assign stall_cnt_o = cnt_q;
    assign hang_o      = hang_q;

endmodule

// File: rtl/fetch_hold_ctrl.sv
// rtl/fetch_hold_ctrl.sv - PC and IF/ID owner that freezes on stop and requests an ID/EX bubble
module fetch_hold_ctrl
    import fetch_hold_ctrl_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEF,
    parameter int          WD_LIMIT = 16,
    parameter int          CNT_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stop,
    input  logic              br_taken,
    input  logic [31:0]       br_target,
    input  logic [INSN_W-1:0] ins_in,
    output logic [31:0]       pc,
    output logic [INSN_W-1:0] ins_IF_ID,
    output logic [31:0]       pc4_IF_ID,
    output logic              valid_IF_ID,
    output logic              bubble_ID_EX,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic              hang
);

    logic [31:0]       pc_q, pc_d;
    logic [INSN_W-1:0] ins_q, ins_d;
    logic [31:0]       pc4_q, pc4_d;
    logic              valid_q, valid_d;
    fetch_state_e      state_q, state_d;
    logic [31:0]       pc_plus4;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= PC_RESET;
            ins_q   <= NOP;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
            state_q <= ST_RUN;
        end else begin
            pc_q    <= pc_d;
            ins_q   <= ins_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            state_q <= state_d;
        end
    end

    assign pc_plus4 = pc_q + 32'd4;

    // Delay-slot semantics: a redirect only steers the PC, IF/ID still takes the slot instruction.
    always_comb begin
        pc_d    = pc_q;
        ins_d   = ins_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (!stop) begin
            ins_d   = ins_in;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            pc_d    = br_taken ? align_word(br_target) : pc_plus4;
        end
    end

    // Diagnostic state only; no datapath action depends on it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:  if (stop)  state_d = ST_HOLD;
            ST_HOLD: if (!stop) state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    fetch_hold_ctrl_hold_ctr #(
        .WD_LIMIT (WD_LIMIT),
        .CNT_W    (CNT_W)
    ) u_hold_ctr (
        .clk         (clk),
        .rst         (reset),
        .stop_i      (stop),
        .stall_cnt_o (stall_cnt),
        .hang_o      (hang)
    );

    logic unused_id_is_beq;
    assign unused_id_is_beq = (ins_q[INSN_W-1 -: OPCODE_W] == OP_BEQ);

    assign pc           = pc_q;
    assign ins_IF_ID    = ins_q;
    assign pc4_IF_ID    = pc4_q;
    assign valid_IF_ID  = valid_q;
    assign bubble_ID_EX = stop;

endmodule

// File: tb/tb_fetch_hold_ctrl.sv
// tb/tb_fetch_hold_ctrl.sv - randomized self-checking bench for fetch_hold_ctrl against a behavioural model
module tb_fetch_hold_ctrl;

    localparam int CNT_W    = 8;
    localparam int WD_LIMIT = 16;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic              clk;
    logic              reset;
    logic              stop;
    logic              br_taken;
    logic [31:0]       br_target;
    logic [31:0]       ins_in;
    logic [31:0]       pc;
    logic [31:0]       ins_IF_ID;
    logic [31:0]       pc4_IF_ID;
    logic              valid_IF_ID;
    logic              bubble_ID_EX;
    logic [CNT_W-1:0]  stall_cnt;
    logic              hang;

    int n_tests;
    int n_fail;

    logic [31:0] m_pc, m_ins, m_pc4;
    logic        m_valid, m_hang;
    int          m_cnt, m_run;

    fetch_hold_ctrl #(
        .PC_RESET (32'h0000_3000),
        .WD_LIMIT (WD_LIMIT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stop         (stop),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .ins_in       (ins_in),
        .pc           (pc),
        .ins_IF_ID    (ins_IF_ID),
        .pc4_IF_ID    (pc4_IF_ID),
        .valid_IF_ID  (valid_IF_ID),
        .bubble_ID_EX (bubble_ID_EX),
        .stall_cnt    (stall_cnt),
        .hang         (hang)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] im_word(input logic [31:0] a);
        return (a * 32'h0000_9E37) ^ 32'h2400_0000;
    endfunction

    task automatic model_reset();
        m_pc    = 32'h0000_3000;
        m_ins   = 32'h0;
        m_pc4   = 32'h0;
        m_valid = 1'b0;
        m_hang  = 1'b0;
        m_cnt   = 0;
        m_run   = 0;
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ".pc"},    pc,                  m_pc);
        chk({ctx, ".ins"},   ins_IF_ID,           m_ins);
        chk({ctx, ".pc4"},   pc4_IF_ID,           m_pc4);
        chk({ctx, ".valid"}, {31'b0, valid_IF_ID}, {31'b0, m_valid});
        chk({ctx, ".cnt"},   32'(stall_cnt),      32'(m_cnt));
        chk({ctx, ".hang"},  {31'b0, hang},       {31'b0, m_hang});
    endtask

    // Called at a negedge; returns at the following negedge after one rising edge.
    task automatic step(input logic s, input logic b, input logic [31:0] t, input logic [31:0] ins);
        stop      = s;
        br_taken  = b;
        br_target = t;
        ins_in    = ins;
        #1;
        chk("bubble", {31'b0, bubble_ID_EX}, {31'b0, s});
        @(posedge clk);
        if (!s) begin
            m_ins   = ins;
            m_pc4   = m_pc + 32'd4;
            m_valid = 1'b1;
            m_pc    = b ? {t[31:2], 2'b00} : m_pc + 32'd4;
            m_run   = 0;
        end else begin
            if (m_cnt < CNT_MAX) m_cnt++;
            if (m_run < WD_LIMIT) m_run++;
            if (m_run >= WD_LIMIT) m_hang = 1'b1;
        end
        @(negedge clk);
        check_all("step");
    endtask

    task automatic step_im(input logic s, input logic b, input logic [31:0] t);
        step(s, b, t, im_word(m_pc));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_all("reset");
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_all("reset_rel");
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        reset     = 1'b0;
        stop      = 1'b0;
        br_taken  = 1'b0;
        br_target = 32'h0;
        ins_in    = 32'h0;
        model_reset();
        @(negedge clk);
        do_reset();
        chk("rst_pc", pc, 32'h0000_3000);

        // Sequential fetch
        step(1'b0, 1'b0, 32'h0, 32'h2400_0001);
        chk("seq1_pc", pc, 32'h0000_3004);
        chk("seq1_valid", {31'b0, valid_IF_ID}, 32'd1);
        chk("seq1_ins", ins_IF_ID, 32'h2400_0001);
        step(1'b0, 1'b0, 32'h0, 32'h2400_0001);
        step(1'b0, 1'b0, 32'h0, 32'h2400_0001);
        chk("seq3_pc", pc, 32'h0000_300C);

        // Two-cycle stall
        step(1'b1, 1'b0, 32'h0, 32'hDEAD_BEEF);
        step(1'b1, 1'b0, 32'h0, 32'hDEAD_BEEF);
        chk("stall_pc", pc, 32'h0000_300C);
        chk("stall_ins", ins_IF_ID, 32'h2400_0001);
        chk("stall_cnt2", 32'(stall_cnt), 32'd2);
        step_im(1'b0, 1'b0, 32'h0);
        chk("resume_pc", pc, 32'h0000_3010);

        // Branch with delay slot
        step(1'b0, 1'b1, 32'h0000_3043, 32'h1111_2222);
        chk("br_pc", pc, 32'h0000_3040);
        chk("br_pc4", pc4_IF_ID, 32'h0000_3014);
        chk("br_slot", ins_IF_ID, 32'h1111_2222);

        // Branch during stop is ignored, retried afterwards
        step_im(1'b1, 1'b1, 32'h0000_5000);
        chk("brstop_pc", pc, 32'h0000_3040);
        step_im(1'b0, 1'b1, 32'h0000_5000);
        chk("brretry_pc", pc, 32'h0000_5000);

        // PC wrap
        step_im(1'b0, 1'b1, 32'hFFFF_FFFE);
        chk("wrap_pre", pc, 32'hFFFF_FFFC);
        step_im(1'b0, 1'b0, 32'h0);
        chk("wrap_pc", pc, 32'h0000_0000);

        // Watchdog
        do_reset();
        for (int i = 0; i < WD_LIMIT - 1; i++) step_im(1'b1, 1'b0, 32'h0);
        chk("wd_15", {31'b0, hang}, 32'd0);
        step_im(1'b1, 1'b0, 32'h0);
        chk("wd_16", {31'b0, hang}, 32'd1);
        step_im(1'b0, 1'b0, 32'h0);
        chk("wd_sticky", {31'b0, hang}, 32'd1);
        chk("wd_cnt", 32'(stall_cnt), 32'd16);

        // Async reset between edges while holding
        step_im(1'b1, 1'b0, 32'h0);
        step_im(1'b1, 1'b0, 32'h0);
        #2;
        reset = 1'b1;
        #1;
        chk("async_pc", pc, 32'h0000_3000);
        chk("async_cnt", 32'(stall_cnt), 32'd0);
        chk("async_hang", {31'b0, hang}, 32'd0);
        chk("async_valid", {31'b0, valid_IF_ID}, 32'd0);
        model_reset();
        @(negedge clk);
        reset  = 1'b0;
        stop   = 1'b0;
        #1;
        check_all("async_rel");

        // Saturation of the (narrowed) stall counter
        for (int i = 0; i < CNT_MAX + 5; i++) step_im(1'b1, 1'b0, 32'h0);
        chk("sat_cnt", 32'(stall_cnt), CNT_MAX);
        do_reset();

        // Random traffic with occasional long stop bursts
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 29) == 0) begin
                int len;
                len = $urandom_range(WD_LIMIT - 3, WD_LIMIT + 3);
                for (int k = 0; k < len; k++) step_im(1'b1, $urandom_range(0, 1) == 1, $urandom);
            end else begin
                step_im($urandom_range(0, 9) < 4, $urandom_range(0, 3) == 0, $urandom);
            end
            if ($urandom_range(0, 149) == 0) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
